test_constants_checker: RTL and testbench
=========================================

# test_constants_checker

Receive-side checker for the incrementing byte test pattern sent over the SPI link. Consumes a received byte bus plus a toggle strobe, in which every edge of START marks a new byte. Locks onto the modulo-256 incrementing sequence, then counts mismatches and accepted bytes for link bring-up and ground test. Sits after the SPI receiver, in the CLK_1KHZ domain, and drives status toward telemetry and LEDs.

## Interface
- LOCK_COUNT, 4: consecutive in-sequence bytes needed to lock (2..255).
- LOSS_COUNT, 3: consecutive mismatches while locked that drop lock (1..255).
- TIMEOUT_CYCLES, 16: idle CLK_1KHZ cycles without a byte before timeout (2..65535).
- CNT_W, 16: width of ERR_COUNT and BYTE_COUNT.

Ports:
- CLK_1KHZ  in  1  system clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high.
- DATA  in  8  received byte; valid in any cycle where START has changed.
- START  in  1  toggle strobe; each level change marks one new byte.
- LOCKED  out  1  high while the checker is in state LOCKED.
- ERR_PULSE  out  1  one-cycle pulse per mismatch counted while locked.
- ERR_COUNT  out  CNT_W  mismatches while locked; saturates at all-ones.
- BYTE_COUNT  out  CNT_W  bytes accepted while locked (match or mismatch); wraps.
- TIMEOUT  out  1  sticky flag: the link went idle after sync began.

## Operation
- Event detect: register start_q, which resets to 0. The event is ev = START ^ start_q. DATA is sampled in the ev cycle.
- Expected value exp (8 bit) and all arithmetic are modulo 256. 8'hFF followed by 8'h00 is a match.
- State machine:
  - HUNT (reset state): on ev, exp <= DATA+1, good <= 1, go to VERIFY.
  - VERIFY, on ev with DATA==exp: good++, exp <= DATA+1. When good reaches LOCK_COUNT, go to LOCKED and clear bad.
  - VERIFY, on ev with a mismatch: resync with exp <= DATA+1 and good <= 1. Stay in VERIFY. No error is counted.
  - LOCKED, on ev: BYTE_COUNT++.
    - Match: exp++, bad <= 0.
    - Mismatch: exp++ so the stride is kept and a single corrupt byte is tolerated. ERR_COUNT++ (saturating), ERR_PULSE=1, bad++.
    - When bad reaches LOSS_COUNT, go to HUNT.
- A mismatch that reaches LOSS_COUNT is counted, pulses ERR_PULSE, and drops to HUNT, all on the same edge.
- Counters are not cleared on loss of lock. Only RESET clears them.
- A RESET assertion at any time clears all state immediately.

## Timing
- Every output is registered and updates on the same edge that samples the event: one-cycle latency from the byte to status.
- Reset values: LOCKED=0, ERR_PULSE=0, ERR_COUNT=0, BYTE_COUNT=0, TIMEOUT=0. Internally: state=HUNT, exp=0, good=0, bad=0, idle=0.
- An event may occur in every cycle; back-to-back events need no gap.
- ERR_PULSE is high for exactly one cycle per counted mismatch.

## Configuration
- Macro PATTERN_CHECK_TIMEOUT_EN.
- Defined:
  - An idle counter clears on ev and otherwise increments in VERIFY and LOCKED.
  - When it reaches TIMEOUT_CYCLES: TIMEOUT <= 1 (sticky until RESET), state goes to HUNT, idle clears.
  - An ev in the same cycle wins: no timeout, and idle clears.
  - The counter is held at 0 in HUNT.
- Undefined: TIMEOUT is tied to 0, and no idle counter or associated logic exists.

## Structure
- Shared package test_pattern_pkg holds:
  - the state encoding localparams: HUNT=2'd0, VERIFY=2'd1, LOCKED=2'd2;
  - the pattern step constant 8'd1;
  - the default widths.
- Sub-module pattern_idle_watchdog, present only under the macro: inputs ev and active, TIMEOUT_CYCLES parameter, one-cycle expire output.

## Test plan
- Driven by the matching incrementing-pattern generator (toggle every cycle, DATA 1,2,3… after reset): events at edges 2,3,4,5 -> LOCKED=1 after edge 5. ERR_COUNT stays 0. BYTE_COUNT counts once per cycle thereafter.
- Locked, DATA sequence 8'hFE, 8'hFF, 8'h00, 8'h01 -> no ERR_PULSE, LOCKED stays 1 across the wrap.
- Locked, one byte corrupted (expected 8'h40, sent 8'hAA), then in sequence resumes at 8'h41 -> one ERR_PULSE, ERR_COUNT=1, LOCKED stays 1.
- Locked, three consecutive corrupted bytes -> ERR_COUNT=3, LOCKED falls on the edge of the third. Clean data resumes -> LOCKED returns 4 events later.
- With PATTERN_CHECK_TIMEOUT_EN, START held constant for 16 cycles while locked -> TIMEOUT=1, LOCKED=0. TIMEOUT stays 1 after relock, until RESET.
- RESET pulsed mid-stream while locked -> all outputs 0 immediately (asynchronous). Relock requires LOCK_COUNT events.

Source files
------------

// File: rtl/test_pattern_pkg.sv
// Shared definitions for the incrementing byte test-pattern checker:
// state encoding, pattern step and default parameter values.
package test_pattern_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;

    localparam logic [7:0] PATTERN_STEP = 8'd1;

    localparam int unsigned DEF_LOCK_COUNT     = 4;
    localparam int unsigned DEF_LOSS_COUNT     = 3;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;
    localparam int unsigned DEF_CNT_W          = 16;

endpackage

// File: rtl/pattern_idle_watchdog.sv
// Idle watchdog for the pattern checker: counts cycles without a byte event
// while active and raises a one-cycle expire. Built only with PATTERN_CHECK_TIMEOUT_EN.
`ifdef PATTERN_CHECK_TIMEOUT_EN
module pattern_idle_watchdog
    import test_pattern_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic CLK_1KHZ,
    input  logic RESET,
    input  logic ev,
    input  logic active,
    output logic expire
);

    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] idle;

    // Fires on the edge where idle would reach TIMEOUT_CYCLES; an event wins.
    assign expire = active && !ev && (idle == IDLE_LAST);

    always_ff @(posedge CLK_1KHZ or posedge RESET) begin
        if (RESET) begin
            idle <= '0;
        end else if (!active || ev || expire) begin
            idle <= '0;
        end else begin
            idle <= idle + 16'd1;
        end
    end

endmodule
`endif

// File: rtl/test_constants_checker.sv
// Receive-side checker for the incrementing byte test pattern on the SPI link.
// Optional idle timeout enabled by defining PATTERN_CHECK_TIMEOUT_EN.
module test_constants_checker
    import test_pattern_pkg::*;
#(
    parameter int unsigned LOCK_COUNT     = DEF_LOCK_COUNT,
    parameter int unsigned LOSS_COUNT     = DEF_LOSS_COUNT,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             CLK_1KHZ,
    input  logic             RESET,
    input  logic [7:0]       DATA,
    input  logic             START,
    output logic             LOCKED,
    output logic             ERR_PULSE,
    output logic [CNT_W-1:0] ERR_COUNT,
    output logic [CNT_W-1:0] BYTE_COUNT,
    output logic             TIMEOUT
);

    generate
        if (LOCK_COUNT < 2 || LOCK_COUNT > 255) begin : g_bad_lock
            $error("LOCK_COUNT out of range");
        end
        if (LOSS_COUNT < 1 || LOSS_COUNT > 255) begin : g_bad_loss
            $error("LOSS_COUNT out of range");
        end
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
            $error("TIMEOUT_CYCLES out of range");
        end
    endgenerate

    localparam logic [7:0]       LOCK_C  = 8'(LOCK_COUNT);
    localparam logic [7:0]       LOSS_C  = 8'(LOSS_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    chk_state_e       state, state_n;
    logic             start_q;
    logic             ev;
    logic [7:0]       exp_q, exp_n;
    logic [7:0]       good, good_n;
    logic [7:0]       bad, bad_n;
    logic [CNT_W-1:0] err_count, err_n;
    logic [CNT_W-1:0] byte_count, byte_n;
    logic             err_pulse, pulse_n;
    logic             wd_expire;

    assign ev = START ^ start_q;

`ifdef PATTERN_CHECK_TIMEOUT_EN
    logic timeout_q;

    pattern_idle_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_wd (
        .CLK_1KHZ(CLK_1KHZ),
        .RESET   (RESET),
        .ev      (ev),
        .active  (state != ST_HUNT),
        .expire  (wd_expire)
    );

    always_ff @(posedge CLK_1KHZ or posedge RESET) begin
        if (RESET) begin
            timeout_q <= 1'b0;
        end else if (wd_expire) begin
            timeout_q <= 1'b1;
        end
    end

    assign TIMEOUT = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign TIMEOUT   = 1'b0;
`endif

    always_ff @(posedge CLK_1KHZ or posedge RESET) begin
        if (RESET) begin
            state      <= ST_HUNT;
            start_q    <= 1'b0;
            exp_q      <= '0;
            good       <= '0;
            bad        <= '0;
            err_count  <= '0;
            byte_count <= '0;
            err_pulse  <= 1'b0;
        end else begin
            state      <= state_n;
            start_q    <= START;
            exp_q      <= exp_n;
            good       <= good_n;
            bad        <= bad_n;
            err_count  <= err_n;
            byte_count <= byte_n;
            err_pulse  <= pulse_n;
        end
    end

    always_comb begin
        state_n = state;
        exp_n   = exp_q;
        good_n  = good;
        bad_n   = bad;
        err_n   = err_count;
        byte_n  = byte_count;
        pulse_n = 1'b0;
        if (ev) begin
            case (state)
                ST_HUNT: begin
                    exp_n   = DATA + PATTERN_STEP;
                    good_n  = 8'd1;
                    state_n = ST_VERIFY;
                end
                ST_VERIFY: begin
                    exp_n = DATA + PATTERN_STEP;
                    if (DATA == exp_q) begin
                        good_n = good + 8'd1;
                        if (good_n == LOCK_C) begin
                            state_n = ST_LOCKED;
                            bad_n   = '0;
                        end
                    end else begin
                        good_n = 8'd1;
                    end
                end
                ST_LOCKED: begin
                    byte_n = byte_count + CNT_ONE;
                    // Stride is kept on a mismatch so one corrupt byte does not desync.
                    exp_n  = exp_q + PATTERN_STEP;
                    if (DATA == exp_q) begin
                        bad_n = '0;
                    end else begin
                        pulse_n = 1'b1;
                        if (err_count != '1) begin
                            err_n = err_count + CNT_ONE;
                        end
                        bad_n = bad + 8'd1;
                        if (bad_n == LOSS_C) begin
                            state_n = ST_HUNT;
                        end
                    end
                end
                default: state_n = ST_HUNT;
            endcase
        end else if (wd_expire) begin
            state_n = ST_HUNT;
        end
    end

    assign LOCKED     = (state == ST_LOCKED);
    assign ERR_PULSE  = err_pulse;
    assign ERR_COUNT  = err_count;
    assign BYTE_COUNT = byte_count;

endmodule

// File: tb/tb_test_constants_checker.sv
// Directed self-checking bench for test_constants_checker; exercises the
// timeout path as well when built with PATTERN_CHECK_TIMEOUT_EN.
module tb_test_constants_checker;

    logic        CLK_1KHZ;
    logic        RESET;
    logic [7:0]  DATA;
    logic        START;
    logic        LOCKED;
    logic        ERR_PULSE;
    logic [15:0] ERR_COUNT;
    logic [15:0] BYTE_COUNT;
    logic        TIMEOUT;

    int n_vec  = 0;
    int n_miss = 0;

    test_constants_checker #(
        .LOCK_COUNT    (4),
        .LOSS_COUNT    (3),
        .TIMEOUT_CYCLES(16),
        .CNT_W         (16)
    ) dut (
        .CLK_1KHZ  (CLK_1KHZ),
        .RESET     (RESET),
        .DATA      (DATA),
        .START     (START),
        .LOCKED    (LOCKED),
        .ERR_PULSE (ERR_PULSE),
        .ERR_COUNT (ERR_COUNT),
        .BYTE_COUNT(BYTE_COUNT),
        .TIMEOUT   (TIMEOUT)
    );

    initial CLK_1KHZ = 1'b0;
    always #5 CLK_1KHZ = ~CLK_1KHZ;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge CLK_1KHZ);
        START = ~START;
        DATA  = d;
        @(posedge CLK_1KHZ);
        #1;
    endtask

    task automatic idle_cyc();
        @(negedge CLK_1KHZ);
        DATA = 8'($urandom);
        @(posedge CLK_1KHZ);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_locked"}, 32'(LOCKED), 0);
        check_val({tag, "_pulse"},  32'(ERR_PULSE), 0);
        check_val({tag, "_errcnt"}, 32'(ERR_COUNT), 0);
        check_val({tag, "_bytecnt"}, 32'(BYTE_COUNT), 0);
        check_val({tag, "_timeout"}, 32'(TIMEOUT), 0);
    endtask

    initial begin
        RESET = 1'b1;
        START = 1'b0;
        DATA  = 8'h00;
        repeat (2) @(posedge CLK_1KHZ);
        #1;
        check_all_zero("reset");
        @(negedge CLK_1KHZ);
        RESET = 1'b0;

        // Acquire lock on 1,2,3,4
        send(8'h01); check_val("acq1_locked", 32'(LOCKED), 0);
        send(8'h02); check_val("acq2_locked", 32'(LOCKED), 0);
        send(8'h03); check_val("acq3_locked", 32'(LOCKED), 0);
        send(8'h04); check_val("acq4_locked", 32'(LOCKED), 1);
        check_val("acq4_bytecnt", 32'(BYTE_COUNT), 0);
        check_val("acq4_errcnt", 32'(ERR_COUNT), 0);
        send(8'h05); check_val("bc_first", 32'(BYTE_COUNT), 1);
        send(8'h06); check_val("bc_second", 32'(BYTE_COUNT), 2);

        // A cycle without a START edge must not count a byte
        idle_cyc();  check_val("noev_bytecnt", 32'(BYTE_COUNT), 2);

        for (int unsigned d = 7; d <= 8'hFD; d++) send(8'(d));
        check_val("run_bytecnt", 32'(BYTE_COUNT), 249);

        // Modulo-256 wrap is in sequence
        send(8'hFE); check_val("wrapFE_pulse", 32'(ERR_PULSE), 0);
        send(8'hFF); check_val("wrapFF_pulse", 32'(ERR_PULSE), 0);
        send(8'h00); check_val("wrap00_pulse", 32'(ERR_PULSE), 0);
        check_val("wrap00_locked", 32'(LOCKED), 1);
        send(8'h01); check_val("wrap01_locked", 32'(LOCKED), 1);
        check_val("wrap_errcnt", 32'(ERR_COUNT), 0);

        for (int unsigned d = 2; d <= 8'h3F; d++) send(8'(d));
        check_val("pre_corrupt_bytecnt", 32'(BYTE_COUNT), 315);

        // Single corrupt byte: expected 8'h40, sent 8'hAA
        send(8'hAA);
        check_val("corrupt_pulse", 32'(ERR_PULSE), 1);
        check_val("corrupt_errcnt", 32'(ERR_COUNT), 1);
        check_val("corrupt_locked", 32'(LOCKED), 1);
        check_val("corrupt_bytecnt", 32'(BYTE_COUNT), 316);
        send(8'h41);
        check_val("resume_pulse", 32'(ERR_PULSE), 0);
        check_val("resume_errcnt", 32'(ERR_COUNT), 1);
        send(8'h42);
        send(8'h43);

        // Three consecutive corrupt bytes drop lock on the third
        send(8'h99); check_val("loss1_locked", 32'(LOCKED), 1);
        send(8'h99); check_val("loss2_locked", 32'(LOCKED), 1);
        check_val("loss2_pulse", 32'(ERR_PULSE), 1);
        send(8'h99);
        check_val("loss3_locked", 32'(LOCKED), 0);
        check_val("loss3_pulse", 32'(ERR_PULSE), 1);
        check_val("loss3_errcnt", 32'(ERR_COUNT), 4);
        check_val("loss3_bytecnt", 32'(BYTE_COUNT), 322);

        // Reacquire, with a resync mismatch in VERIFY that is not an error
        send(8'h50); check_val("hunt_locked", 32'(LOCKED), 0);
        send(8'h51);
        send(8'h70); check_val("resync_pulse", 32'(ERR_PULSE), 0);
        send(8'h71);
        send(8'h72); check_val("resync3_locked", 32'(LOCKED), 0);
        send(8'h73); check_val("relock_locked", 32'(LOCKED), 1);
        check_val("relock_errcnt", 32'(ERR_COUNT), 4);
        check_val("relock_bytecnt", 32'(BYTE_COUNT), 322);

`ifdef PATTERN_CHECK_TIMEOUT_EN
        repeat (15) idle_cyc();
        check_val("idle15_locked", 32'(LOCKED), 1);
        check_val("idle15_timeout", 32'(TIMEOUT), 0);
        idle_cyc();
        check_val("idle16_timeout", 32'(TIMEOUT), 1);
        check_val("idle16_locked", 32'(LOCKED), 0);
        send(8'h80);
        send(8'h81);
        send(8'h82);
        send(8'h83);
        check_val("tmo_relock_locked", 32'(LOCKED), 1);
        check_val("tmo_sticky", 32'(TIMEOUT), 1);
        send(8'h84);
`else
        repeat (20) idle_cyc();
        check_val("idle_locked", 32'(LOCKED), 1);
        check_val("idle_timeout", 32'(TIMEOUT), 0);
        send(8'h74);
`endif
        check_val("pre_reset_pulse", 32'(ERR_PULSE), 0);
        send(8'hEE);
        check_val("pre_reset_err", 32'(ERR_PULSE), 1);
        check_val("pre_reset_errcnt", 32'(ERR_COUNT), 5);
        check_val("pre_reset_bytecnt", 32'(BYTE_COUNT), 324);

        // Asynchronous reset mid-stream, observed before the next clock edge
        #1;
        RESET = 1'b1;
        START = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge CLK_1KHZ);
        RESET = 1'b0;

        send(8'h10); check_val("post_rst1_locked", 32'(LOCKED), 0);
        send(8'h11);
        send(8'h12); check_val("post_rst3_locked", 32'(LOCKED), 0);
        send(8'h13); check_val("post_rst4_locked", 32'(LOCKED), 1);
        check_val("post_rst_bytecnt", 32'(BYTE_COUNT), 0);
        check_val("post_rst_errcnt", 32'(ERR_COUNT), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
